// File: rtl/ccsds_iq_pkg.sv
// Shared I/Q word format for the CCSDS modem: field positions, sync patterns and sample entry type.
// Used by both the receive sink and the transmit packer.
package ccsds_iq_pkg;

   localparam int unsigned IQ_WORD_W = 32;
   localparam int unsigned SAMPLE_W  = 13;

   localparam int unsigned I_MSB = 29;
   localparam int unsigned I_LSB = 17;
   localparam int unsigned Q_MSB = 13;
   localparam int unsigned Q_LSB = 1;

   localparam logic [1:0] I_SYNC = 2'b10;
   localparam logic [1:0] Q_SYNC = 2'b01;

   typedef struct packed {
      logic                last;
      logic [SAMPLE_W-1:0] i;
      logic [SAMPLE_W-1:0] q;
   } iq_entry_t;

   localparam int unsigned IQ_ENTRY_W = $bits(iq_entry_t);

   function automatic iq_entry_t unpack_word(input logic [IQ_WORD_W-1:0] word, input logic last);
      iq_entry_t e;
      e.last = last;
      e.i    = word[I_MSB:I_LSB];
      e.q    = word[Q_MSB:Q_LSB];
      return e;
   endfunction

   // Both sync pairs present and both pad bits clear.
   function automatic logic sync_ok(input logic [IQ_WORD_W-1:0] word);
      return (word[31:30] == I_SYNC) && (word[15:14] == Q_SYNC) && !word[16] && !word[0];
   endfunction

endpackage

// File: rtl/ccsds_rx_iq_axis_sink_if.sv
// AXI4-Stream word channel carrying packed I/Q words between the radio and the sink.
interface ccsds_rx_iq_axis_sink_if;
   import ccsds_iq_pkg::*;

   logic [IQ_WORD_W-1:0]   S_AXIS_TDATA;
   logic [IQ_WORD_W/8-1:0] S_AXIS_TSTRB;
   logic                   S_AXIS_TLAST;
   logic                   S_AXIS_TVALID;
   logic                   S_AXIS_TREADY;

   modport master (
      output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
      input  S_AXIS_TREADY
   );

   modport slave (
      input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
      output S_AXIS_TREADY
   );

endinterface

// File: rtl/ccsds_iq_fifo.sv
// Synchronous FIFO with occupancy count; head entry is visible on rd_data while not empty.
module ccsds_iq_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 27
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally; count carries the extra bit that separates full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ccsds_rx_iq_axis_sink.sv
// Receive-side AXI4-Stream I/Q sink: unpacks words into a sample FIFO feeding a registered sample port.
// Sync checking and word dropping are enabled by defining CCSDS_RX_SYNC_CHECK_EN.
module ccsds_rx_iq_axis_sink
   import ccsds_iq_pkg::*;
#(
   parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH           = 16,
   parameter int unsigned ERR_CNT_WIDTH        = 16
) (
   input  logic                           S_AXIS_ACLK,
   input  logic                           S_AXIS_ARESET,
   ccsds_rx_iq_axis_sink_if.slave         s_axis,
   output logic [SAMPLE_W-1:0]            i_data_o,
   output logic [SAMPLE_W-1:0]            q_data_o,
   output logic                           last_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
   output logic                           sync_err_o,
   output logic [ERR_CNT_WIDTH-1:0]       sync_err_cnt_o
);

   logic [C_S_AXIS_TDATA_WIDTH-1:0] word;
   logic                            xfer;
   logic                            sync_good;
   logic                            fifo_full;
   logic                            fifo_empty;
   logic                            load;
   iq_entry_t                       wr_entry;
   iq_entry_t                       head;
   logic                            unused_bits;

   assign word        = s_axis.S_AXIS_TDATA;
   assign unused_bits = ^{s_axis.S_AXIS_TSTRB, word[31:30], word[16], word[15:14], word[0]};

   assign s_axis.S_AXIS_TREADY = !fifo_full;
   assign xfer                 = s_axis.S_AXIS_TVALID && !fifo_full;
   assign wr_entry             = unpack_word(word, s_axis.S_AXIS_TLAST);

`ifdef CCSDS_RX_SYNC_CHECK_EN
   assign sync_good = sync_ok(word);

   // Bad words complete the handshake but are never written; the counter sticks at all-ones.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         sync_err_o     <= 1'b0;
         sync_err_cnt_o <= '0;
      end else begin
         sync_err_o <= xfer && !sync_good;
         if (xfer && !sync_good && (sync_err_cnt_o != '1))
            sync_err_cnt_o <= sync_err_cnt_o + ERR_CNT_WIDTH'(1);
      end
   end
`else
   assign sync_good      = 1'b1;
   assign sync_err_o     = 1'b0;
   assign sync_err_cnt_o = '0;
`endif

   ccsds_iq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (IQ_ENTRY_W)
   ) u_fifo (
      .clk     (S_AXIS_ACLK),
      .rst     (S_AXIS_ARESET),
      .wr_en   (xfer && sync_good),
      .wr_data (wr_entry),
      .rd_en   (load),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_level_o)
   );

   assign load = !fifo_empty && (!valid_o || ready_i);

   // Output register: refills whenever it is empty or being consumed, otherwise holds.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         valid_o  <= 1'b0;
         i_data_o <= '0;
         q_data_o <= '0;
         last_o   <= 1'b0;
      end else if (load) begin
         valid_o  <= 1'b1;
         i_data_o <= head.i;
         q_data_o <= head.q;
         last_o   <= head.last;
      end else if (ready_i) begin
         valid_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ccsds_rx_iq_axis_sink.sv
// Self-checking bench for ccsds_rx_iq_axis_sink: vector table, corner sequences and a randomized
// run against a queue-based reference model. Expectations follow CCSDS_RX_SYNC_CHECK_EN.
module tb_ccsds_rx_iq_axis_sink;
   import ccsds_iq_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned ECW   = 4;
`ifdef CCSDS_RX_SYNC_CHECK_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic [12:0] i_data;
   logic [12:0] q_data;
   logic        last;
   logic        valid;
   logic [4:0]  level;
   logic        sync_err;
   logic [ECW-1:0] err_cnt;

   always #5 clk = ~clk;

   ccsds_rx_iq_axis_sink_if axis();

   ccsds_rx_iq_axis_sink #(
      .C_S_AXIS_TDATA_WIDTH (32),
      .FIFO_DEPTH           (DEPTH),
      .ERR_CNT_WIDTH        (ECW)
   ) dut (
      .S_AXIS_ACLK    (clk),
      .S_AXIS_ARESET  (rst),
      .s_axis         (axis),
      .i_data_o       (i_data),
      .q_data_o       (q_data),
      .last_o         (last),
      .valid_o        (valid),
      .ready_i        (ready),
      .fifo_level_o   (level),
      .sync_err_o     (sync_err),
      .sync_err_cnt_o (err_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: FIFO contents as a queue plus the presented sample.
   iq_entry_t mq[$];
   iq_entry_t mout;
   bit        mov;
   bit        mpulse;
   int        mcnt;

   // Observed DUT activity.
   int dut_acc    = 0;
   int dut_deliv  = 0;
   int dut_pulses = 0;
   int max_lvl    = 0;

   typedef struct {
      logic [31:0] word;
      logic        last;
      logic [12:0] exp_i;
      logic [12:0] exp_q;
      bit          bad;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit word_good(input logic [31:0] w);
      return (w[31] == 1'b1) && (w[30] == 1'b0) && (w[16] == 1'b0) &&
             (w[15] == 1'b0) && (w[14] == 1'b1) && (w[0] == 1'b0);
   endfunction

   function automatic logic [31:0] pack(input logic [12:0] i, input logic [12:0] q);
      return {2'b10, i, 1'b0, 2'b01, q, 1'b0};
   endfunction

   // One clock: advance the model from the current inputs, then compare everything after the edge.
   task automatic tick();
      bit acc, good, load, cons;
      iq_entry_t e;
      if (valid && ready && !rst) dut_deliv++;
      if (axis.S_AXIS_TVALID && axis.S_AXIS_TREADY && !rst) dut_acc++;
      if (rst) begin
         mq.delete();
         mov    = 1'b0;
         mout   = '0;
         mpulse = 1'b0;
         mcnt   = 0;
      end else begin
         acc  = axis.S_AXIS_TVALID && (mq.size() < DEPTH);
         good = !SYNC_EN || word_good(axis.S_AXIS_TDATA);
         cons = mov && ready;
         load = (mq.size() > 0) && (!mov || ready);
         if (load) begin
            mout = mq.pop_front();
            mov  = 1'b1;
         end else if (cons) begin
            mov = 1'b0;
         end
         mpulse = acc && !good;
         if (mpulse && mcnt < (2**ECW - 1)) mcnt++;
         if (acc && good) begin
            e.last = axis.S_AXIS_TLAST;
            e.i    = axis.S_AXIS_TDATA[29:17];
            e.q    = axis.S_AXIS_TDATA[13:1];
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      if (sync_err) dut_pulses++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      chk("m_tready", 32'(axis.S_AXIS_TREADY), 32'(mq.size() < DEPTH));
      chk("m_valid",  32'(valid),   32'(mov));
      chk("m_i",      32'(i_data),  32'(mout.i));
      chk("m_q",      32'(q_data),  32'(mout.q));
      chk("m_last",   32'(last),    32'(mout.last));
      chk("m_level",  32'(level),   32'(mq.size()));
      chk("m_err",    32'(sync_err), 32'(mpulse));
      chk("m_errcnt", 32'(err_cnt), 32'(mcnt));
   endtask

   task automatic drive(input logic [31:0] w, input logic l, input logic v);
      axis.S_AXIS_TDATA  = w;
      axis.S_AXIS_TLAST  = l;
      axis.S_AXIS_TVALID = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(32'h0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int a0, d0, p0, k, n, good_acc, tot_acc;
      logic [31:0] w;
      bit keep;
      logic [31:0] masks[4];

      masks[0] = 32'h8000_0000; masks[1] = 32'h0001_0000;
      masks[2] = 32'h0000_8000; masks[3] = 32'h0000_0001;
      vecs[0] = '{32'h95786468, 1'b1, 13'h0ABC, 13'h1234, 1'b0};
      vecs[1] = '{pack(13'h1FFF, 13'h0000), 1'b0, 13'h1FFF, 13'h0000, 1'b0};
      vecs[2] = '{pack(13'h0000, 13'h1FFF), 1'b1, 13'h0000, 13'h1FFF, 1'b0};
      vecs[3] = '{32'h15786468, 1'b1, 13'h0ABC, 13'h1234, 1'b1};
      vecs[4] = '{32'h95796468, 1'b0, 13'h0ABC, 13'h1234, 1'b1};
      vecs[5] = '{32'h9578E468, 1'b1, 13'h0ABC, 13'h1234, 1'b1};
      vecs[6] = '{32'h95786469, 1'b0, 13'h0ABC, 13'h1234, 1'b1};
      vecs[7] = '{pack(13'h0555, 13'h1AAA), 1'b1, 13'h0555, 13'h1AAA, 1'b0};

      axis.S_AXIS_TSTRB = 4'hF;
      ready = 1'b0;
      do_reset();
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_tready", 32'(axis.S_AXIS_TREADY), 32'd1);

      // Vector table: latency, unpacking and per-word sync decision.
      ready = 1'b1;
      for (int r = 0; r < 8; r++) begin
         keep = !(SYNC_EN && vecs[r].bad);
         drive(vecs[r].word, vecs[r].last, 1'b1);
         tick();
         drive(32'h0, 1'b0, 1'b0);
         chk("tbl_err", 32'(sync_err), 32'(SYNC_EN && vecs[r].bad));
         chk("tbl_lat", 32'(valid), 32'd0);
         chk("tbl_lvl", 32'(level), 32'(keep));
         tick();
         chk("tbl_valid", 32'(valid), 32'(keep));
         if (keep) begin
            chk("tbl_i", 32'(i_data), 32'(vecs[r].exp_i));
            chk("tbl_q", 32'(q_data), 32'(vecs[r].exp_q));
            chk("tbl_last", 32'(last), 32'(vecs[r].last));
         end
         tick();
         chk("tbl_drain", 32'(valid), 32'd0);
      end

      // Backpressure: 16 FIFO entries plus the output register fill, then drain in order.
      do_reset();
      ready = 1'b0;
      a0 = dut_acc;
      k = 0;
      for (int c = 0; c < 30 && k < 20; c++) begin
         drive(pack(13'(k), 13'(100 + k)), 1'b0, 1'b1);
         n = dut_acc;
         tick();
         if (dut_acc != n) k++;
      end
      chk("bp_acc", 32'(dut_acc - a0), 32'd17);
      chk("bp_tready", 32'(axis.S_AXIS_TREADY), 32'd0);
      chk("bp_level", 32'(level), 32'd16);
      for (int c = 0; c < 4; c++) tick();
      chk("bp_hold_v", 32'(valid), 32'd1);
      chk("bp_hold_i", 32'(i_data), 32'd0);
      chk("bp_hold_q", 32'(q_data), 32'd100);
      drive(32'h0, 1'b0, 1'b0);
      ready = 1'b1;
      d0 = dut_deliv;
      for (int c = 0; c < 25; c++) tick();
      chk("bp_deliv", 32'(dut_deliv - d0), 32'd17);

      // Bad word between two good ones.
      do_reset();
      ready = 1'b1;
      d0 = dut_deliv;
      p0 = dut_pulses;
      drive(pack(13'h0011, 13'h0022), 1'b0, 1'b1); tick();
      drive(32'h15786468, 1'b1, 1'b1);             tick();
      drive(pack(13'h0033, 13'h0044), 1'b1, 1'b1); tick();
      drive(32'h0, 1'b0, 1'b0);
      for (int c = 0; c < 6; c++) tick();
      chk("trio_out", 32'(dut_deliv - d0), SYNC_EN ? 32'd2 : 32'd3);
      chk("trio_pulse", 32'(dut_pulses - p0), SYNC_EN ? 32'd1 : 32'd0);
      chk("trio_cnt", 32'(err_cnt), SYNC_EN ? 32'd1 : 32'd0);

      // Counter saturation.
      do_reset();
      p0 = dut_pulses;
      for (int c = 0; c < 20; c++) begin
         drive(32'h15786468, 1'b0, 1'b1);
         tick();
      end
      drive(32'h0, 1'b0, 1'b0);
      tick();
      chk("sat_cnt", 32'(err_cnt), SYNC_EN ? 32'd15 : 32'd0);
      chk("sat_pulses", 32'(dut_pulses - p0), SYNC_EN ? 32'd20 : 32'd0);

      // Reset with 8 entries queued behind a held output sample.
      do_reset();
      ready = 1'b0;
      for (int c = 0; c < 9; c++) begin
         drive(pack(13'(c + 50), 13'(c)), 1'b0, 1'b1);
         tick();
      end
      drive(32'h0, 1'b0, 1'b0);
      tick();
      chk("mid_level", 32'(level), 32'd8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", 32'(valid), 32'd0);
      chk("mid_lvl0", 32'(level), 32'd0);
      chk("mid_tready", 32'(axis.S_AXIS_TREADY), 32'd1);
      tick();
      chk("mid_tready1", 32'(axis.S_AXIS_TREADY), 32'd1);
      ready = 1'b1;
      d0 = dut_deliv;
      for (int c = 0; c < 10; c++) tick();
      chk("mid_stale", 32'(dut_deliv - d0), 32'd0);

      // Randomized handshakes with incrementing samples and occasional bad sync.
      do_reset();
      d0 = dut_deliv;
      n = 0;
      good_acc = 0;
      tot_acc = 0;
      for (int c = 0; c < 20000 && tot_acc < 1000; c++) begin
         w = pack(13'(n), 13'(8191 - (n % 8192)));
         keep = ($urandom_range(0, 9) != 0);
         if (!keep) w = w ^ masks[$urandom_range(0, 3)];
         drive(w, 1'((n % 7) == 6), 1'($urandom_range(0, 1)));
         ready = 1'($urandom_range(0, 1));
         a0 = dut_acc;
         tick();
         if (dut_acc != a0) begin
            tot_acc++;
            if (keep) begin
               good_acc++;
               n++;
            end
         end
      end
      drive(32'h0, 1'b0, 1'b0);
      ready = 1'b1;
      for (int c = 0; c < 40; c++) tick();
      chk("rnd_done", 32'(tot_acc), 32'd1000);
      chk("rnd_deliv", 32'(dut_deliv - d0), SYNC_EN ? 32'(good_acc) : 32'(tot_acc));
      chk("rnd_maxlvl", 32'(max_lvl <= 16), 32'd1);
      chk("rnd_empty", 32'(level), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
